mem_access_ctrl: RTL and testbench

//  Initiator side of the unified byte-addressed memory port (MemRead/MemWrite/funct3/addr/data_in/data_out).

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_if.sv | 15 +
 rtl/misalign_chk.sv | 19 +
 rtl/mem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified memory-port access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Unified byte-addressed memory port: controller drives master, memory implements slave.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output MemRead, MemWrite, funct3, addr, data_in, input data_out);
  modport slave  (input MemRead, MemWrite, funct3, addr, data_in, output data_out);
endinterface

// File: rtl/misalign_chk.sv
// Alignment check for load/store size codes; compiled only with MISALIGN_TRAP_EN.
`ifdef MISALIGN_TRAP_EN
module misalign_chk
  import mem_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misalign
);
  always_comb begin
    misalign = 1'b0;
    case (funct3)
      F3_H, F3_HU: misalign = addr_lo[0];
      F3_W:        misalign = |addr_lo;
      default:     misalign = 1'b0;
    endcase
  end
endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch and load/store onto one memory port, one access per cycle.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
//
// state    | meaning
// ST_IDLE  | port quiet, waiting for an eligible request
// ST_FETCH | port reads the latched fetch address
// ST_DATA  | port performs the latched load/store (suppressed when trapped)
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W       = ADDR_W_DEF,
  parameter int         DATA_W       = DATA_W_DEF,
  parameter logic [2:0] FETCH_FUNCT3 = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_instr,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_misalign,
  output logic              busy,
  mem_access_ctrl_if.master mem
);

  state_t            state;
  logic              ls_mis;
  logic              ls_we_q;
  logic              ls_mis_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ls_elig;
  logic              fetch_elig;

`ifdef MISALIGN_TRAP_EN
  misalign_chk u_misalign_chk (
    .funct3   (ls_funct3),
    .addr_lo  (ls_addr[1:0]),
    .misalign (ls_mis)
  );
`else
  assign ls_mis = 1'b0;
`endif

  // A requester is still holding its served request while in access or ack cycle.
  assign ls_elig    = ls_req && (state != ST_DATA) && !ls_ack;
  assign fetch_elig = fetch_req && (state != ST_FETCH) && !fetch_ack;
  assign busy       = (state != ST_IDLE);

  assign mem.MemRead  = mem_rd_q;
  assign mem.MemWrite = mem_wr_q;
  assign mem.funct3   = f3_q;
  assign mem.addr     = addr_q;
  assign mem.data_in  = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ls_we_q     <= 1'b0;
      ls_mis_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fetch_ack   <= 1'b0;
      fetch_instr <= '0;
      ls_ack      <= 1'b0;
      ls_rdata    <= '0;
      ls_misalign <= 1'b0;
    end else begin
      fetch_ack   <= 1'b0;
      ls_ack      <= 1'b0;
      ls_misalign <= 1'b0;

      if (state == ST_FETCH) begin
        fetch_instr <= mem.data_out;
        fetch_ack   <= 1'b1;
      end
      if (state == ST_DATA) begin
        ls_rdata    <= (ls_we_q || ls_mis_q) ? '0 : mem.data_out;
        ls_ack      <= 1'b1;
        ls_misalign <= ls_mis_q;
      end

      // Data beats fetch so the MEM stage drains first.
      if (ls_elig) begin
        state    <= ST_DATA;
        addr_q   <= ls_addr;
        f3_q     <= ls_funct3;
        wdata_q  <= ls_wdata;
        ls_we_q  <= ls_we;
        ls_mis_q <= ls_mis;
        mem_rd_q <= !ls_we && !ls_mis;
        mem_wr_q <= ls_we && !ls_mis;
      end else if (fetch_elig) begin
        state    <= ST_FETCH;
        addr_q   <= fetch_addr;
        f3_q     <= FETCH_FUNCT3;
        wdata_q  <= '0;
        mem_rd_q <= 1'b1;
        mem_wr_q <= 1'b0;
      end else begin
        state    <= ST_IDLE;
        addr_q   <= '0;
        f3_q     <= '0;
        wdata_q  <= '0;
        mem_rd_q <= 1'b0;
        mem_wr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, scoreboard queues, corner sequences.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, ls_req, ls_we;
  logic [AW-1:0] fetch_addr, ls_addr;
  logic [2:0]    ls_funct3;
  logic [DW-1:0] ls_wdata;
  logic          fetch_ack, ls_ack, ls_misalign, busy;
  logic [DW-1:0] fetch_instr, ls_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FETCH_FUNCT3(3'b010)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_instr (fetch_instr),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_funct3   (ls_funct3),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_ack      (ls_ack),
    .ls_rdata    (ls_rdata),
    .ls_misalign (ls_misalign),
    .busy        (busy),
    .mem         (mem_if)
  );

  // Little-endian byte memory with combinational sized read
  logic [7:0] mem_arr [256];
  logic [7:0] a0, a1, a2, a3;
  assign a0 = mem_if.addr;
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  always_comb begin
    mem_if.data_out = '0;
    if (mem_if.MemRead) begin
      case (mem_if.funct3)
        F3_B:    mem_if.data_out = {{24{mem_arr[a0][7]}}, mem_arr[a0]};
        F3_BU:   mem_if.data_out = {24'd0, mem_arr[a0]};
        F3_H:    mem_if.data_out = {{16{mem_arr[a1][7]}}, mem_arr[a1], mem_arr[a0]};
        F3_HU:   mem_if.data_out = {16'd0, mem_arr[a1], mem_arr[a0]};
        F3_W:    mem_if.data_out = {mem_arr[a3], mem_arr[a2], mem_arr[a1], mem_arr[a0]};
        default: mem_if.data_out = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_if.MemWrite) begin
      mem_arr[a0] = mem_if.data_in[7:0];
      if (mem_if.funct3[1:0] != 2'b00) mem_arr[a1] = mem_if.data_in[15:8];
      if (mem_if.funct3[1:0] == 2'b10) begin
        mem_arr[a2] = mem_if.data_in[23:16];
        mem_arr[a3] = mem_if.data_in[31:24];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic [31:0] f_q[$];
  exp_t        ls_q[$];

  int cyc = 0;
  int busy_cnt = 0, wr_cnt = 0, ls_ack_cnt = 0, f_ack_cnt = 0;
  int ls_ack_cyc = 0, f_ack_cyc = 0;
  logic        snap_rd, snap_wr;
  logic [2:0]  snap_f3;
  logic [7:0]  snap_addr;
  logic [31:0] snap_wd;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expectations pushed at request time, popped on each ack
  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      snap_rd   = mem_if.MemRead;
      snap_wr   = mem_if.MemWrite;
      snap_f3   = mem_if.funct3;
      snap_addr = mem_if.addr;
      snap_wd   = mem_if.data_in;
    end
    if (mem_if.MemWrite) wr_cnt++;
    if (fetch_ack) begin
      f_ack_cnt++;
      f_ack_cyc = cyc;
      if (f_q.size() == 0) check("unexpected fetch_ack", 64'(fetch_ack), 64'd0);
      else check("fetch_instr", 64'(fetch_instr), 64'(f_q.pop_front()));
    end
    if (ls_ack) begin
      exp_t e;
      ls_ack_cnt++;
      ls_ack_cyc = cyc;
      if (ls_q.size() == 0) check("unexpected ls_ack", 64'(ls_ack), 64'd0);
      else begin
        e = ls_q.pop_front();
        check("ls_rdata", 64'(ls_rdata), 64'(e.rdata));
        check("ls_misalign", 64'(ls_misalign), 64'(e.mis));
      end
    end
  end

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    bit   done;
    logic exp_rd, exp_wr;
    @(posedge clk); #1;
    busy_cnt = 0;
    wr_cnt   = 0;
    if (v.fetch) begin
      fetch_addr = v.addr;
      fetch_req  = 1'b1;
      f_q.push_back(v.exp_rdata);
    end else begin
      ls_we     = v.we;
      ls_funct3 = v.f3;
      ls_addr   = v.addr;
      ls_wdata  = v.wdata;
      ls_req    = 1'b1;
      ls_q.push_back('{rdata: v.exp_rdata, mis: v.exp_mis});
    end
    done = 0;
    lat  = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (v.fetch ? fetch_ack : ls_ack) done = 1;
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    ls_req    = 1'b0;
    exp_rd = v.fetch || (!v.we && !v.exp_mis);
    exp_wr = !v.fetch && v.we && !v.exp_mis;
    check($sformatf("vec%0d ack seen", idx), 64'(done), 64'd1);
    check($sformatf("vec%0d latency", idx), 64'(lat), 64'd3);
    check($sformatf("vec%0d busy cycles", idx), 64'(busy_cnt), 64'd1);
    check($sformatf("vec%0d rd/wr", idx), {62'd0, snap_rd, snap_wr}, {62'd0, exp_rd, exp_wr});
    check($sformatf("vec%0d funct3", idx), 64'(snap_f3), v.fetch ? 64'd2 : 64'(v.f3));
    check($sformatf("vec%0d addr", idx), 64'(snap_addr), 64'(v.addr));
    if (!v.fetch && v.we)
      check($sformatf("vec%0d data_in", idx), 64'(snap_wd), 64'(v.wdata));
    check($sformatf("vec%0d write cycles", idx), 64'(wr_cnt), 64'(exp_wr));
  endtask

  initial begin
    bit ld, fd, found;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    {mem_arr[8'h0B], mem_arr[8'h0A], mem_arr[8'h09], mem_arr[8'h08]} = 32'h00C00093;
    {mem_arr[8'h13], mem_arr[8'h12], mem_arr[8'h11], mem_arr[8'h10]} = 32'hCAFEF00D;
    {mem_arr[8'h01], mem_arr[8'h00], mem_arr[8'hFF], mem_arr[8'hFE]} = 32'h44332211;

    //           fetch we  f3     addr    wdata         exp_rdata     mis
    vecs[0]  = '{1'b1, 1'b0, F3_W,  8'h08, 32'h0,        32'h00C00093, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, F3_W,  8'h20, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b0, F3_B,  8'h23, 32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, F3_BU, 8'h23, 32'h0,        32'h000000DE, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, F3_H,  8'h22, 32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, F3_HU, 8'h20, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, F3_W,  8'h20, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, F3_B,  8'h24, 32'h1234565A, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b0, F3_W,  8'h24, 32'h0,        32'h0000005A, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, F3_W,  8'hFE, 32'h0,        32'h44332211, 1'b0};
    vecs[14] = '{1'b0, 1'b0, F3_B,  8'h11, 32'h0,        32'hFFFFFFF0, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[10] = '{1'b0, 1'b1, F3_H,  8'h21, 32'h00001234, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 1'b0, F3_W,  8'h20, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, F3_H,  8'h11, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 1'b0, F3_W,  8'h12, 32'h0,        32'h0,        1'b1};
`else
    vecs[10] = '{1'b0, 1'b1, F3_H,  8'h21, 32'h00001234, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 1'b0, F3_W,  8'h20, 32'h0,        32'hDE1234EF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, F3_H,  8'h11, 32'h0,        32'hFFFFFEF0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, F3_W,  8'h12, 32'h0,        32'h0000CAFE, 1'b0};
`endif

    rst = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
    #12;
    check("reset acks/busy", {61'd0, fetch_ack, ls_ack, busy}, 64'd0);
    check("reset port ctrl", {59'd0, mem_if.MemRead, mem_if.MemWrite, mem_if.funct3}, 64'd0);
    check("reset port addr/data", {24'd0, mem_if.addr, mem_if.data_in}, 64'd0);
    check("reset results", {fetch_instr, ls_rdata}, 64'd0);
    check("reset ls_misalign", 64'(ls_misalign), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Fetch and load on the same edge: data first, fetch back-to-back
    @(posedge clk); #1;
    fetch_addr = 8'h08; fetch_req = 1'b1;
    f_q.push_back(32'h00C00093);
    ls_we = 1'b0; ls_funct3 = F3_W; ls_addr = 8'h10; ls_req = 1'b1;
    ls_q.push_back('{rdata: 32'hCAFEF00D, mis: 1'b0});
    ld = 0; fd = 0;
    for (int i = 0; i < 10 && !(ld && fd); i++) begin
      @(negedge clk);
      if (ls_ack) ld = 1;
      if (fetch_ack) fd = 1;
      @(posedge clk); #1;
      if (ld) ls_req = 1'b0;
      if (fd) fetch_req = 1'b0;
    end
    ls_req = 1'b0; fetch_req = 1'b0;
    check("simul both acked", {62'd0, ld, fd}, 64'd3);
    check("simul fetch_ack after ls_ack", 64'(f_ack_cyc - ls_ack_cyc), 64'd1);

    // Held request through its ack cycle must not be re-issued
    ls_ack_cnt = 0;
    run_vec(100, '{1'b0, 1'b0, F3_W, 8'h10, 32'h0, 32'hCAFEF00D, 1'b0});
    busy_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("held req single ack", 64'(ls_ack_cnt), 64'd1);
    check("held req no reissue", 64'(busy_cnt), 64'd0);

    // Asynchronous reset in the middle of a store
    @(posedge clk); #1;
    ls_ack_cnt = 0;
    ls_we = 1'b1; ls_funct3 = F3_W; ls_addr = 8'h30; ls_wdata = 32'h11223344; ls_req = 1'b1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (mem_if.MemWrite) found = 1;
    end
    check("store reached DATA", 64'(found), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst MemWrite/MemRead", {62'd0, mem_if.MemWrite, mem_if.MemRead}, 64'd0);
    check("rst busy/acks", {61'd0, busy, ls_ack, fetch_ack}, 64'd0);
    check("rst port fields", {21'd0, mem_if.funct3, mem_if.addr, mem_if.data_in}, 64'd0);
    check("rst results", {fetch_instr, ls_rdata}, 64'd0);
    ls_req = 1'b0; ls_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst no late ls_ack", 64'(ls_ack_cnt), 64'd0);
    check("rst store not committed", 64'(mem_arr[8'h30]), 64'd0);
    check("scoreboard drained", 64'(f_q.size() + ls_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
